// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: WIDTH-bit add/subtract done one nibble per cycle through a single external 4-bit CLA slice.
// Latency: start sampled at edge E0, done pulses in the cycle after edge E0+N (N = WIDTH/4); busy for N cycles.
// Backpressure: none; start is ignored while busy. Define SERIAL_ADD_ABORT_EN to add an abort input for RUN.
module serial_add_ctrl #(
  parameter int WIDTH = 32  // multiple of 4, at least 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SERIAL_ADD_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [3:0]       slice_x,
  output logic [3:0]       slice_y,
  output logic             slice_cin,
  input  logic [3:0]       slice_f,
  input  logic             slice_cout,
  input  logic             slice_c2
);

  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             abort_w;
  logic [3:0]       x_nib;
  logic [3:0]       y_nib;
  logic [WIDTH-1:0] acc_upd;

`ifdef SERIAL_ADD_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Select the current operand nibbles and build the accumulator with the slice result merged in
  always_comb begin
    x_nib   = 4'h0;
    y_nib   = 4'h0;
    acc_upd = acc_q;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        x_nib              = a_q[4*i +: 4];
        y_nib              = b_q[4*i +: 4];
        acc_upd[4*i +: 4]  = slice_f;
      end
    end
  end

  // Slice is driven only while a nibble step is in flight; quiet zeros otherwise
  always_comb begin
    slice_x   = 4'h0;
    slice_y   = 4'h0;
    slice_cin = 1'b0;
    if (state_q == RUN) begin
      slice_x   = x_nib;
      slice_y   = y_nib;
      slice_cin = carry_q;
    end
  end

  // Next-state: accept in IDLE/DONE, step one nibble per cycle in RUN, commit on the last nibble
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert B here and seed the carry with 1
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (abort_w) begin
          // Abort wins over the commit; results from the last completed op stay visible
          state_d = IDLE;
        end else begin
          acc_d   = acc_upd;
          carry_d = slice_cout;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            sum_d   = acc_upd;
            cout_d  = slice_cout;
            // Signed overflow: carry into the MSB differs from carry out of it
            ovf_d   = slice_c2 ^ slice_cout;
            zero_d  = (acc_upd == '0);
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: randomized and directed checks of serial_add_ctrl against a whole-word arithmetic model.
// Latency: expects done in the (N+1)th cycle after start is sampled, busy for exactly N cycles.
// Backpressure: exercises ignored start during RUN, back-to-back starts from DONE, reset and abort mid-RUN.
module tb_serial_add_ctrl;

  localparam int W = 32;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, ovf, zero;
  logic [W-1:0] sum;
  logic [3:0]   slice_x, slice_y, slice_f;
  logic         slice_cin, slice_cout, slice_c2;

  int n_cmp = 0;
  int n_err = 0;

  // model of the last committed result
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf = 1'b0;
  logic         m_zero = 1'b0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef SERIAL_ADD_ABORT_EN
    .abort      (abort),
`endif
    .start      (start),
    .sub        (sub),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .sum        (sum),
    .cout       (cout),
    .ovf        (ovf),
    .zero       (zero),
    .slice_x    (slice_x),
    .slice_y    (slice_y),
    .slice_cin  (slice_cin),
    .slice_f    (slice_f),
    .slice_cout (slice_cout),
    .slice_c2   (slice_c2)
  );

  // Behavioural 4-bit adder slice: sum, carry out of bit 3, carry into bit 3
  always_comb begin
    logic [4:0] s5;
    logic [3:0] s3;
    s5 = {1'b0, slice_x} + {1'b0, slice_y} + {4'b0, slice_cin};
    s3 = {1'b0, slice_x[2:0]} + {1'b0, slice_y[2:0]} + {3'b0, slice_cin};
    slice_f    = s5[3:0];
    slice_cout = s5[4];
    slice_c2   = s3[3];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one operation at the current negedge and follow it to done; poke re-pulses start mid-RUN
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                       input bit poke, input string tag);
    logic [W-1:0] e_sum, bb, tmp, lmask;
    logic [W:0]   full, part, mask;
    logic         e_cout, e_ovf;
    int           lat, bcnt, k;
    bit           hold_ok, slice_ok;
    if (ts) begin
      e_sum  = ta - tb_v;
      e_cout = (ta >= tb_v);
      e_ovf  = (ta[W-1] != tb_v[W-1]) && (e_sum[W-1] != ta[W-1]);
    end else begin
      full   = {1'b0, ta} + {1'b0, tb_v};
      e_sum  = full[W-1:0];
      e_cout = full[W];
      e_ovf  = (ta[W-1] == tb_v[W-1]) && (e_sum[W-1] != ta[W-1]);
    end
    bb = ts ? ~tb_v : tb_v;
    a = ta; b = tb_v; sub = ts; start = 1'b1;
    lat = 0; bcnt = 0; hold_ok = 1'b1; slice_ok = 1'b1;
    while (lat < 4 * N) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
      end
      if (poke && lat == 3) begin start = 1'b1; a = $urandom; b = $urandom; end
      if (poke && lat == 4) start = 1'b0;
      if (done) break;
      if (busy) bcnt++;
      if (sum !== m_sum || cout !== m_cout || ovf !== m_ovf || zero !== m_zero) hold_ok = 1'b0;
      if (lat <= N) begin
        k     = lat - 1;
        tmp   = ta >> (4 * k);
        mask  = ((W+1)'(1) << (4 * k)) - (W+1)'(1);
        lmask = mask[W-1:0];
        part  = {1'b0, ta & lmask} + {1'b0, bb & lmask} + {{W{1'b0}}, ts};
        if (slice_x !== tmp[3:0]) slice_ok = 1'b0;
        tmp = bb >> (4 * k);
        if (slice_y !== tmp[3:0]) slice_ok = 1'b0;
        if (slice_cin !== part[4*k]) slice_ok = 1'b0;
      end
    end
    chk({tag, "_latency"}, 64'(lat), 64'(N + 1));
    chk({tag, "_busy_cycles"}, 64'(bcnt), 64'(N));
    chk({tag, "_hold_during_run"}, 64'(hold_ok), 64'd1);
    chk({tag, "_slice_drive"}, 64'(slice_ok), 64'd1);
    chk({tag, "_sum"}, 64'(sum), 64'(e_sum));
    chk({tag, "_cout"}, 64'(cout), 64'(e_cout));
    chk({tag, "_ovf"}, 64'(ovf), 64'(e_ovf));
    chk({tag, "_zero"}, 64'(zero), 64'(e_sum == '0));
    chk({tag, "_slice_idle"}, 64'({slice_x, slice_y, slice_cin}), 64'd0);
    m_sum = e_sum; m_cout = e_cout; m_ovf = e_ovf; m_zero = (e_sum == '0);
  endtask

  // Start an op and stop at the negedge where the counter equals steps-1
  task automatic start_and_run(input int steps);
    a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1)); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (steps - 1) @(negedge clk);
  endtask

  task automatic expect_no_done(input string tag);
    bit seen;
    seen = 1'b0;
    repeat (2 * N) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int g;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'({sum, cout, ovf, zero}), 64'd0);
    chk("rst_slice", 64'({slice_x, slice_y, slice_cin}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, "wrap_zero");
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "pos_ovf");
    do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, "sub_borrow");
    do_op(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, "sub_b2b");
    do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, "neg_ovf");
    do_op($urandom, $urandom, 1'b0, 1'b1, "start_ignored");

    for (int i = 0; i < 24; i++) begin
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: ra = {1'b0, ra[W-2:0]};
        default: ;
      endcase
      g = $urandom_range(0, 2);
      if (g > 0) begin
        @(negedge clk);
        chk("done_one_pulse", 64'(done), 64'd0);
        repeat (g - 1) @(negedge clk);
      end
      do_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
    end

    // reset at RUN step 4 aborts and clears
    start_and_run(4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_result", 64'({sum, cout, ovf, zero}), 64'd0);
    chk("midrst_slice", 64'({slice_x, slice_y, slice_cin}), 64'd0);
    expect_no_done("midrst_no_done");
    m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_zero = 1'b0;
    do_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0, "after_rst");

`ifdef SERIAL_ADD_ABORT_EN
    do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, "pre_abort");
    start_and_run(4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_sum_kept", 64'(sum), 64'(m_sum));
    expect_no_done("abort_no_done");
    start_and_run(N);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_last_done", 64'(done), 64'd0);
    chk("abort_last_kept", 64'({sum, cout, ovf, zero}), 64'({m_sum, m_cout, m_ovf, m_zero}));
    do_op($urandom, $urandom, 1'b1, 1'b0, "after_abort");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
